// File: rtl/audio_volume_scaler_pkg.sv
// ----------------------------------------------------------------------------
// audio_vol_pkg
//  Shared constants and helpers for the audio volume scaler.
//  therm_to_level : 8-bit thermometer code -> {legal, level[3:0]}
//  level_to_gain  : level (0..8) -> Q8 gain (level*32, 256 = unity)
// ----------------------------------------------------------------------------
package audio_vol_pkg;

    localparam int               VOL_LEVELS = 8;
    localparam int               GAIN_W     = 9;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

    // A legal thermometer code is a contiguous run of ones from bit 0, i.e.
    // code+1 is a power of two, so code & (code+1) has no bits left in [7:0].
    function automatic logic [4:0] therm_to_level(input logic [VOL_LEVELS-1:0] code);
        logic [VOL_LEVELS:0] plus1;
        logic                legal;
        logic [3:0]          lvl;
        plus1 = {1'b0, code} + 9'd1;
        legal = ((plus1[VOL_LEVELS-1:0] & code) == '0);
        lvl   = '0;
        for (int i = 0; i < VOL_LEVELS; i++) begin
            lvl = lvl + {3'b000, code[i]};
        end
        return {legal, lvl};
    endfunction

    function automatic logic [GAIN_W-1:0] level_to_gain(input logic [3:0] level);
        return {level, 5'b00000};
    endfunction

endpackage

// File: rtl/audio_volume_scaler_if.sv
// ----------------------------------------------------------------------------
// audio_volume_scaler_if
//  Bundles the sample stream, volume code and gain status of the scaler.
//  slave  : the scaler side (consumes samples/volume, drives results/status)
//  master : the driving side (effects chain / volume register / monitor)
// ----------------------------------------------------------------------------
interface audio_volume_scaler_if #(
    parameter int DATA_W = 24
);
    import audio_vol_pkg::*;

    logic [VOL_LEVELS-1:0]     vol_therm;
    logic signed [DATA_W-1:0]  sample_in;
    logic                      sample_in_valid;
    logic signed [DATA_W-1:0]  sample_out;
    logic                      sample_out_valid;
    logic [GAIN_W-1:0]         cur_gain;
    logic                      ramping;
    logic                      code_err;

    modport slave (
        input  vol_therm, sample_in, sample_in_valid,
        output sample_out, sample_out_valid, cur_gain, ramping, code_err
    );

    modport master (
        output vol_therm, sample_in, sample_in_valid,
        input  sample_out, sample_out_valid, cur_gain, ramping, code_err
    );

endinterface

// File: rtl/audio_volume_scaler_gain_ramp.sv
// ----------------------------------------------------------------------------
// vol_gain_ramp
//  Tracks the target gain from the thermometer volume code and slews the
//  applied gain toward it by at most RAMP_STEP per accepted sample.
//  Clk, Reset   : clock, synchronous active-high reset
//  vol_therm_i  : thermometer volume code, sampled every cycle
//  strobe_i     : sample accepted this cycle (ramp advances only then)
//  cur_gain_o   : gain currently applied (Q8), registered
//  ramping_o    : cur_gain != target
//  code_err_o   : last sampled code was not a legal thermometer code
// ----------------------------------------------------------------------------
module vol_gain_ramp
    import audio_vol_pkg::*;
#(
    parameter int RAMP_STEP = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [VOL_LEVELS-1:0] vol_therm_i,
    input  logic                  strobe_i,
    output logic [GAIN_W-1:0]     cur_gain_o,
    output logic                  ramping_o,
    output logic                  code_err_o
);

    localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);

    logic [GAIN_W-1:0] target_q, target_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic              code_err_q, code_err_d;
    logic              code_legal;
    logic [3:0]        code_lvl;
    logic [GAIN_W-1:0] diff;

    assign {code_legal, code_lvl} = therm_to_level(vol_therm_i);

    // Illegal codes leave the target where it was.
    always_comb begin
        target_d   = target_q;
        code_err_d = ~code_legal;
        if (code_legal) begin
            target_d = level_to_gain(code_lvl);
        end
    end

    // Step size is clamped to the remaining distance so the ramp never overshoots.
    always_comb begin
        gain_d = gain_q;
        diff   = '0;
        if (strobe_i) begin
            if (gain_q < target_q) begin
                diff   = target_q - gain_q;
                gain_d = gain_q + ((diff < STEP) ? diff : STEP);
            end else if (gain_q > target_q) begin
                diff   = gain_q - target_q;
                gain_d = gain_q - ((diff < STEP) ? diff : STEP);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            target_q   <= '0;
            gain_q     <= '0;
            code_err_q <= 1'b0;
        end else begin
            target_q   <= target_d;
            gain_q     <= gain_d;
            code_err_q <= code_err_d;
        end
    end

    assign cur_gain_o = gain_q;
    assign ramping_o  = (gain_q != target_q);
    assign code_err_o = code_err_q;

endmodule

// File: rtl/audio_volume_scaler.sv
// ----------------------------------------------------------------------------
// audio_volume_scaler
//  Applies a ramped Q8 volume gain to a signed audio stream, 2-cycle latency,
//  full rate, no backpressure.
//  Clk, Reset : clock, synchronous active-high reset
//  vif.slave  : vol_therm, sample_in, sample_in_valid in;
//               sample_out, sample_out_valid, cur_gain, ramping, code_err out
// ----------------------------------------------------------------------------
module audio_volume_scaler
    import audio_vol_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int RAMP_STEP = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    audio_volume_scaler_if.slave vif
);

    localparam int PW = DATA_W + 10;

    logic [GAIN_W-1:0]        cur_gain;
    logic signed [DATA_W-1:0] s1_q;
    logic [GAIN_W-1:0]        g1_q;
    logic [1:0]               vld_pipe_q;
    logic signed [DATA_W-1:0] sample_out_q, sample_out_d;
    logic signed [PW-1:0]     s1_ext, g1_ext, prod;
    logic                     unused_prod_bits;

    vol_gain_ramp #(
        .RAMP_STEP (RAMP_STEP)
    ) u_ramp (
        .Clk         (Clk),
        .Reset       (Reset),
        .vol_therm_i (vif.vol_therm),
        .strobe_i    (vif.sample_in_valid),
        .cur_gain_o  (cur_gain),
        .ramping_o   (vif.ramping),
        .code_err_o  (vif.code_err)
    );

    // Gain is zero-extended to stay non-negative in the signed multiply.
    assign s1_ext       = PW'(s1_q);
    assign g1_ext       = PW'({1'b0, g1_q});
    assign prod         = s1_ext * g1_ext;
    // Dropping the low 8 bits of a two's complement product is floor(prod/256).
    assign sample_out_d = prod[DATA_W+7:8];
    // Gain <= 256 keeps the result inside DATA_W, so the top bits are pure sign.
    assign unused_prod_bits = ^{prod[PW-1:DATA_W+8], prod[7:0]};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_pipe_q   <= '0;
            s1_q         <= '0;
            g1_q         <= '0;
            sample_out_q <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], vif.sample_in_valid};
            // Stage 1 holds the gain in force before this sample's ramp step.
            if (vif.sample_in_valid) begin
                s1_q <= vif.sample_in;
                g1_q <= cur_gain;
            end
            if (vld_pipe_q[0]) begin
                sample_out_q <= sample_out_d;
            end
        end
    end

    assign vif.sample_out       = sample_out_q;
    assign vif.sample_out_valid = vld_pipe_q[1];
    assign vif.cur_gain         = cur_gain;

endmodule

// File: tb/tb_audio_volume_scaler.sv
module tb_audio_volume_scaler;

    logic Clk = 1'b0;
    logic Reset;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    typedef struct {
        logic [23:0] data;
        int          at_cyc;
    } exp_t;

    exp_t sb_q[$];

    audio_volume_scaler_if #(.DATA_W(24)) vif ();

    audio_volume_scaler #(
        .DATA_W    (24),
        .RAMP_STEP (1)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .vif   (vif)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Output monitor: every presented sample must match the oldest expectation,
    // both in value and in arrival cycle.
    always @(negedge Clk) begin
        if (vif.sample_out_valid) begin
            total_cnt++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_out: got %h at cycle %0d, none expected", vif.sample_out, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (vif.sample_out !== e.data || cyc != e.at_cyc)
                    $display("FAIL sample_out: got %h @%0d, want %h @%0d", vif.sample_out, cyc, e.data, e.at_cyc);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act != exp) $display("FAIL %s: got %0d, want %0d", name, act, exp);
        else pass_cnt++;
    endtask

    // Drive inputs just after a rising edge; they are sampled on the next one.
    task automatic drive(input logic v, input int s);
        @(posedge Clk);
        #1;
        vif.sample_in_valid = v;
        vif.sample_in       = 24'(s);
    endtask

    task automatic step(input logic v, input int s, input int e);
        exp_t x;
        drive(v, s);
        if (v) begin
            x.data   = 24'(e);
            x.at_cyc = cyc + 2;
            sb_q.push_back(x);
        end
    endtask

    initial begin
        Reset               = 1'b1;
        vif.vol_therm       = 8'hFF;
        vif.sample_in_valid = 1'b0;
        vif.sample_in       = '0;

        // 1: reset state, then ramp 0 -> 256 at +1 per strobe
        repeat (3) drive(0, 0);
        chk("rst_cur_gain", int'(vif.cur_gain), 0);
        chk("rst_ramping", int'(vif.ramping), 0);
        chk("rst_code_err", int'(vif.code_err), 0);
        chk("rst_sample_out", int'(vif.sample_out), 0);
        chk("rst_out_valid", int'(vif.sample_out_valid), 0);
        Reset = 1'b0;
        drive(0, 0);
        chk("t1_ramping_start", int'(vif.ramping), 1);
        for (int n = 0; n < 300; n++)
            step(1, 1000, (1000 * ((n < 256) ? n : 256)) >> 8);
        drive(0, 0);
        chk("t1_gain_unity", int'(vif.cur_gain), 256);
        chk("t1_ramping_done", int'(vif.ramping), 0);

        // 2: settle at half gain, check rounding toward -inf
        vif.vol_therm = 8'h0F;
        for (int n = 0; n < 130; n++) step(1, 0, 0);
        drive(0, 0);
        chk("t2_gain_half", int'(vif.cur_gain), 128);
        step(1, -1000, -500);
        step(1, -1, -1);
        step(1, 3, 1);
        drive(0, 0);

        // 3: illegal code holds the target
        vif.vol_therm = 8'h05;
        drive(0, 0);
        chk("t3_code_err_set", int'(vif.code_err), 1);
        chk("t3_gain_hold", int'(vif.cur_gain), 128);
        chk("t3_not_ramping", int'(vif.ramping), 0);
        step(1, 100, 50);
        drive(0, 0);
        chk("t3_gain_after_strobe", int'(vif.cur_gain), 128);
        vif.vol_therm = 8'h0F;
        drive(0, 0);
        chk("t3_code_err_clr", int'(vif.code_err), 0);

        // 4: unity gain passes full-scale values unchanged
        vif.vol_therm = 8'hFF;
        for (int n = 0; n < 130; n++) step(1, 0, 0);
        drive(0, 0);
        chk("t4_gain_unity", int'(vif.cur_gain), 256);
        step(1, 'h7FFFFF, 'h7FFFFF);
        step(1, 'h800000, 'h800000);
        repeat (4) drive(0, 0);
        chk("t4_drained", sb_q.size(), 0);

        // 5: reset with two samples in flight flushes them
        drive(1, 500);
        drive(1, 600);
        Reset = 1'b1;
        drive(0, 0);
        chk("t5_cur_gain", int'(vif.cur_gain), 0);
        chk("t5_sample_out", int'(vif.sample_out), 0);
        chk("t5_out_valid", int'(vif.sample_out_valid), 0);
        Reset = 1'b0;
        vif.vol_therm = 8'h00;
        repeat (3) drive(0, 0);
        chk("t5_idle_gain", int'(vif.cur_gain), 0);

        // 6: strobe every 4th cycle while ramping 0 -> 64
        vif.vol_therm = 8'h03;
        drive(0, 0);
        chk("t6_ramping_start", int'(vif.ramping), 1);
        for (int k = 0; k < 64; k++) begin
            step(1, 256, k);
            drive(0, 0);
            chk($sformatf("t6_gain_step%0d", k), int'(vif.cur_gain), k + 1);
            chk($sformatf("t6_ramping%0d", k), int'(vif.ramping), (k == 63) ? 0 : 1);
            drive(0, 0);
            drive(0, 0);
            chk($sformatf("t6_gain_hold%0d", k), int'(vif.cur_gain), k + 1);
        end

        repeat (4) drive(0, 0);
        chk("final_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
